pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, address/PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'hBFC00000, PC value after reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, minimum 2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 stall  input  1  hold PC and RAS; lower priority than redirects.
REQ-007 jalr  input  1  register-indirect jump this cycle.
REQ-008 jalr_target  input  XLEN  rs1+imm from ALU.
REQ-009 branch_taken  input  1  PC-relative branch/JAL taken.
REQ-010 branch_imm  input  XLEN  signed byte offset added to current pc.
REQ-011 ras_push  input  1  call: push pc+4.
REQ-012 ras_pop  input  1  return: pop top entry.
REQ-013 pc  output  XLEN  current fetch address.
REQ-014 pc_plus4  output  XLEN  pc+4, combinational.
REQ-015 ras_top  output  XLEN  top RAS entry, combinational; 0 when empty.
REQ-016 ras_valid  output  1  RAS non-empty.
REQ-017 misalign_err  output  1  registered one-cycle pulse on misaligned target.

Function
REQ-018 Next-PC priority: rst > jalr > branch_taken > stall > pc+4.
REQ-019 jalr: next pc = {jalr_target[XLEN-1:1],1'b0}; fires regardless of stall.
REQ-020 branch_taken without jalr: next pc = pc + branch_imm, modulo 2^XLEN; fires regardless of stall.
REQ-021 Neither redirect, stall high: pc holds.
REQ-022 Otherwise: next pc = pc+4, wrapping modulo 2^XLEN (all-ones-minus-3 -> 0).
REQ-023 Redirect target with bit[1] set: pc holds, misalign_err=1 next cycle; no RAS update that cycle.
REQ-024 RAS ops only when stall low or a redirect fires in the same cycle.
REQ-025 Push writes pc_plus4 at top+1; full push overwrites oldest entry (circular), count saturates at RAS_DEPTH.
REQ-026 Pop on empty: no change, no error.
REQ-027 Simultaneous push and pop: top entry replaced with pc_plus4, count unchanged; if empty, acts as push.
REQ-028 Latency: every update visible on pc one cycle after the qualifying edge.

Reset
REQ-029 rst high at an edge: pc=RESET_VEC, RAS count=0, ras_valid=0, misalign_err=0; overrides all inputs, including mid-redirect.
REQ-030 RAS storage contents not reset; ras_top forced to 0 while empty.

Structure
REQ-031 Shared package pc_pkg: XLEN default, RESET_VEC default, INSTR_BYTES=4, next-pc select enum {SEL_RESET,SEL_JALR,SEL_BRANCH,SEL_HOLD,SEL_SEQ}.
REQ-032 One sub-module ras_stack (parametrised depth/width; push, pop, top, valid) instantiated once.

Verification
REQ-033 rst 1 cycle, then 3 idle cycles -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C.
REQ-034 pc=0xBFC00010, branch_taken with imm=-16, stall=1 -> next pc 0xBFC00000; jalr with target 0x1001 and branch_taken both high -> pc 0x1000.
REQ-035 jalr with target 0x1002 -> pc holds, misalign_err high exactly one cycle.
REQ-036 Five pushes at pc 0x0,0x4,0x8,0xC,0x10 (DEPTH 4), then four pops -> ras_top 0x14,0x10,0xC,0x8, then ras_valid=0, fifth pop no change.
REQ-037 pc=0xFFFFFFFC, idle -> pc 0x0; stall held 3 cycles -> pc constant, push ignored.
REQ-038 rst asserted in same cycle as jalr and ras_push -> pc 0xBFC00000, ras_valid 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and the next-pc select encoding for the fetch PC generator.
package pc_pkg;
  localparam int          DEFAULT_XLEN      = 32;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'hBFC00000;
  localparam int          INSTR_BYTES       = 4;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_JALR,
    SEL_BRANCH,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_e;
endpackage

// File: rtl/pc_gen_if.sv
// Control inputs and fetch-address outputs of pc_gen, plus the next-pc select for observation.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
);
  // No valid/ready handshake here: every input is sampled on each rising clk
  // edge, and every output is valid for the whole cycle that follows it.
  logic            stall;
  logic            jalr;
  logic [XLEN-1:0] jalr_target;
  logic            branch_taken;
  logic [XLEN-1:0] branch_imm;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic            misalign_err;
  pc_sel_e         pc_sel;

  modport master (
    output stall, jalr, jalr_target, branch_taken, branch_imm, ras_push, ras_pop,
    input  pc, pc_plus4, ras_top, ras_valid, misalign_err, pc_sel
  );

  modport slave (
    input  stall, jalr, jalr_target, branch_taken, branch_imm, ras_push, ras_pop,
    output pc, pc_plus4, ras_top, ras_valid, misalign_err, pc_sel
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, pop on empty is ignored.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             do_push;
  logic             do_replace;
  logic             do_pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  always_comb begin
    empty      = (count == '0);
    // Push+pop on a non-empty stack is a replace of the top entry.
    do_replace = push && pop && !empty;
    do_push    = push && !do_replace;
    do_pop     = pop && !push && !empty;
    wr_en      = do_push || do_replace;
    wr_idx     = do_replace ? top_ptr : top_ptr + PTR_W'(1);
    valid      = !empty;
    top        = empty ? '0 : mem[top_ptr];
  end

  // Storage is deliberately left out of reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (do_push) begin
      top_ptr <= top_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (do_pop) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, jalr/branch redirects, stall hold, sequential +4, and a return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misalign;
  logic            misalign_q;
  logic            ras_en;
  pc_sel_e         sel;

  always_comb begin
    pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
    redirect = bus.jalr || bus.branch_taken;
    target   = bus.jalr ? {bus.jalr_target[XLEN-1:1], 1'b0} : pc_q + bus.branch_imm;
    misalign = redirect && target[1];

    if (rst)                   sel = SEL_RESET;
    else if (bus.jalr)         sel = SEL_JALR;
    else if (bus.branch_taken) sel = SEL_BRANCH;
    else if (bus.stall)        sel = SEL_HOLD;
    else                       sel = SEL_SEQ;

    pc_d = pc_q;
    case (sel)
      SEL_RESET:            pc_d = RESET_VEC;
      SEL_JALR, SEL_BRANCH: pc_d = misalign ? pc_q : target;
      SEL_HOLD:             pc_d = pc_q;
      SEL_SEQ:              pc_d = pc_plus4;
      default:              pc_d = pc_q;
    endcase

    // A misaligned redirect is squashed entirely, including its call/return.
    ras_en = !rst && (!bus.stall || redirect) && !misalign;
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    misalign_q <= rst ? 1'b0 : misalign;
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.ras_push && ras_en),
    .pop   (bus.ras_pop && ras_en),
    .din   (pc_plus4),
    .top   (bus.ras_top),
    .valid (bus.ras_valid)
  );

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.misalign_err = misalign_q;
  assign bus.pc_sel       = sel;
endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen against a queue-based reference model of the fetch PC and return stack.
module tb_pc_gen;
  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [W-1:0] RVEC = 32'hBFC00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(W)) bus ();

  pc_gen #(.XLEN(W), .RESET_VEC(RVEC), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: architectural pc, stack as a queue (back = top), error flag.
  logic [W-1:0] m_pc;
  logic [W-1:0] ras_q[$];
  logic         m_err;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic         redir;
    logic [W-1:0] tgt;
    logic         mis;
    logic [W-1:0] ret;
    if (rst) begin
      m_pc  = RVEC;
      ras_q.delete();
      m_err = 1'b0;
    end else begin
      redir = bus.jalr || bus.branch_taken;
      tgt   = bus.jalr ? (bus.jalr_target & ~32'd1) : m_pc + bus.branch_imm;
      mis   = redir && tgt[1];
      m_err = mis;
      ret   = m_pc + 32'd4;
      if ((!bus.stall || redir) && !mis) begin
        if (bus.ras_push && bus.ras_pop && ras_q.size() != 0) begin
          ras_q[ras_q.size()-1] = ret;
        end else if (bus.ras_push) begin
          ras_q.push_back(ret);
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end else if (bus.ras_pop && ras_q.size() != 0) begin
          void'(ras_q.pop_back());
        end
      end
      if (mis)        m_pc = m_pc;
      else if (redir) m_pc = tgt;
      else if (!bus.stall) m_pc = m_pc + 32'd4;
    end
    exp_q.push_back(m_pc);
  endtask

  task automatic compare_all();
    logic [W-1:0] e_pc;
    logic [W-1:0] e_top;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e_pc  = exp_q.pop_front();
    e_top = (ras_q.size() != 0) ? ras_q[ras_q.size()-1] : '0;
    check("pc", bus.pc, e_pc);
    check("pc_plus4", bus.pc_plus4, e_pc + 32'd4);
    check("ras_top", bus.ras_top, e_top);
    check("ras_valid", {31'd0, bus.ras_valid}, {31'd0, ras_q.size() != 0});
    check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic st, input logic j, input logic [W-1:0] jt,
                       input logic b, input logic [W-1:0] bi,
                       input logic pu, input logic po);
    bus.stall        = st;
    bus.jalr         = j;
    bus.jalr_target  = jt;
    bus.branch_taken = b;
    bus.branch_imm   = bi;
    bus.ras_push     = pu;
    bus.ras_pop      = po;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    check("rst_pc", bus.pc, 32'hBFC00000);
    rst = 1'b0;

    // Sequential fetch out of reset.
    step(); check("seq1", bus.pc, 32'hBFC00004);
    step(); check("seq2", bus.pc, 32'hBFC00008);
    step(); check("seq3", bus.pc, 32'hBFC0000C);
    step(); check("seq4", bus.pc, 32'hBFC00010);

    // Branch beats stall; jalr beats branch and clears bit 0.
    drive(1'b1, 1'b0, '0, 1'b1, -32'sd16, 1'b0, 1'b0);
    step(); check("br_stall", bus.pc, 32'hBFC00000);
    drive(1'b0, 1'b1, 32'h1001, 1'b1, 32'h40, 1'b0, 1'b0);
    step(); check("jalr_pri", bus.pc, 32'h00001000);

    // Misaligned jalr holds pc and pulses the error once.
    drive(1'b0, 1'b1, 32'h1002, 1'b0, '0, 1'b0, 1'b0);
    step(); check("mis_hold", bus.pc, 32'h00001000);
    check("mis_pulse", {31'd0, bus.misalign_err}, 32'd1);
    idle();
    step(); check("mis_clear", {31'd0, bus.misalign_err}, 32'd0);

    // Overfill the stack, then drain it past empty.
    drive(1'b0, 1'b1, 32'h0, 1'b0, '0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      step();
    end
    check("ras_full_top", bus.ras_top, 32'h14);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step();
    end
    check("ras_drained", {31'd0, bus.ras_valid}, 32'd0);
    check("ras_top_empty", bus.ras_top, 32'd0);

    // Wrap at the top of the address space; stall freezes pc and RAS.
    drive(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, '0, 1'b0, 1'b0);
    step();
    idle();
    step(); check("wrap", bus.pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      step();
    end
    check("stall_pc", bus.pc, 32'h0);
    check("stall_nopush", {31'd0, bus.ras_valid}, 32'd0);

    // Reset overrides a simultaneous jalr and push.
    idle();
    step();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h2000, 1'b0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("rst_ovr_pc", bus.pc, 32'hBFC00000);
    check("rst_ovr_valid", {31'd0, bus.ras_valid}, 32'd0);
    rst = 1'b0;
    idle();

    for (int c = 0; c < 600; c++) begin
      logic [W-1:0] jt;
      logic [W-1:0] bi;
      jt = $urandom();
      if ($urandom_range(0, 1) == 0) jt[1] = 1'b0;
      bi = W'($signed($urandom_range(0, 255)) - 128) << 2;
      if ($urandom_range(0, 7) == 0) bi = bi + 32'd2;
      rst = ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, jt,
            $urandom_range(0, 5) == 0, bi,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
